board_traffic_harness: RTL and testbench

BOARD_TRAFFIC_HARNESS -- requirements
Module: board_traffic_harness

---
 rtl/board_traffic_harness.sv | 201 ++++++++++++++++++++
 tb/tb_board_traffic_harness.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_traffic_harness.sv
// board_traffic_harness: board-level NoC traffic generator and checker.
// Define HARNESS_SEQ_CHECK_EN to add per-(dst,src) in-order sequence checking.
module board_traffic_harness #(
    parameter int NODES         = 16,
    parameter int PKT_W         = 32,
    parameter int PKTS_PER_NODE = 64,
    parameter int TIMEOUT_CYC   = 65535,
    parameter int HB_BIT        = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [NODES*PKT_W-1:0] inj_data,
    output logic [NODES-1:0]       inj_val,
    input  logic [NODES-1:0]       inj_rdy,
    input  logic [NODES*PKT_W-1:0] ej_data,
    input  logic [NODES-1:0]       ej_val,
    output logic [3:0]             led,
    output logic                   busy,
    output logic [15:0]            err_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    localparam int TOTAL = NODES * PKTS_PER_NODE;
    localparam int SW    = (NODES > 1) ? $clog2(NODES) : 1;

    logic [2:0]       state;
    logic [15:0]      sent [NODES];
    logic [7:0]       rot  [NODES];
    logic [31:0]      rx_total;
    logic [31:0]      tmo;
    logic [HB_BIT:0]  hb;

    logic             go;
    logic             active;
    logic             all_done;
    logic             xfer_any;
    logic             tmo_hit;
    logic [8:0]       n_rx;
    logic [8:0]       n_err;
    logic [16:0]      err_sum;
    logic [7:0]       ej_src [NODES];
    logic [7:0]       ej_dst [NODES];
    logic [15:0]      ej_seq [NODES];
    logic [NODES-1:0] ej_bad;

    assign go       = start && (state == S_IDLE || state == S_PASS ||
                                state == S_FAIL);
    assign active   = (state == S_RUN) || (state == S_DRAIN);
    assign busy     = active;
    assign xfer_any = |(inj_val & inj_rdy);
    assign led      = {state == S_FAIL, state == S_PASS, busy, hb[HB_BIT]};
    assign err_sum  = {1'b0, err_cnt} + 17'(n_err);
    assign tmo_hit  = active && !(|ej_val) && !xfer_any &&
                      (tmo + 32'd1 >= 32'(TIMEOUT_CYC));

    // Present the next packet of every node that still owes transfers.
    always_comb begin
        int d;
        d        = 0;
        inj_val  = '0;
        inj_data = '0;
        all_done = 1'b1;
        for (int s = 0; s < NODES; s++) begin
            // rot[s] tracks k mod (NODES-1), so no divider is needed.
            d = s + 1 + int'(rot[s]);
            if (d >= NODES) d = d - NODES;
            if (sent[s] != 16'(PKTS_PER_NODE)) all_done = 1'b0;
            if (state == S_RUN && sent[s] != 16'(PKTS_PER_NODE)) begin
                inj_val[s] = 1'b1;
                inj_data[s*PKT_W +: 32] = {8'(s), 8'(d), sent[s]};
            end
        end
    end

`ifdef HARNESS_SEQ_CHECK_EN
    logic [15:0] exp_seq [NODES][NODES];

    // Expected seq per (dst,src) pair; advances on each ejection from a legal src.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < NODES; d++)
                for (int s = 0; s < NODES; s++)
                    exp_seq[d][s] <= '0;
        end else if (go) begin
            for (int d = 0; d < NODES; d++)
                for (int s = 0; s < NODES; s++)
                    exp_seq[d][s] <= '0;
        end else begin
            for (int n = 0; n < NODES; n++)
                if (ej_val[n] && int'(ej_src[n]) < NODES)
                    exp_seq[n][ej_src[n][SW-1:0]] <=
                        exp_seq[n][ej_src[n][SW-1:0]] + 16'd1;
        end
    end
`else
    logic seq_unused;

    // The seq field is deliberately ignored in this build.
    always_comb begin
        seq_unused = 1'b0;
        for (int n = 0; n < NODES; n++) seq_unused = seq_unused ^ (^ej_seq[n]);
    end
`endif

    // Classify every ejected packet this cycle; one error per failing packet.
    always_comb begin
        n_rx   = '0;
        n_err  = '0;
        ej_bad = '0;
        for (int n = 0; n < NODES; n++) begin
            ej_src[n] = ej_data[n*PKT_W+24 +: 8];
            ej_dst[n] = ej_data[n*PKT_W+16 +: 8];
            ej_seq[n] = ej_data[n*PKT_W +: 16];
            if (ej_val[n]) begin
                // Packets beyond the run total are found by position in this cycle.
                ej_bad[n] = (int'(ej_dst[n]) != n) ||
                            (int'(ej_src[n]) >= NODES) ||
                            (int'(ej_src[n]) == n) ||
                            !active ||
                            (rx_total + 32'(n_rx) >= 32'(TOTAL));
`ifdef HARNESS_SEQ_CHECK_EN
                if (int'(ej_src[n]) < NODES &&
                    ej_seq[n] != exp_seq[n][ej_src[n][SW-1:0]])
                    ej_bad[n] = 1'b1;
`endif
                n_rx  = n_rx + 9'd1;
                n_err = n_err + 9'(ej_bad[n]);
            end
        end
    end

    // Per-node transfer count and destination rotation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NODES; s++) begin
                sent[s] <= '0;
                rot[s]  <= '0;
            end
        end else if (go) begin
            for (int s = 0; s < NODES; s++) begin
                sent[s] <= '0;
                rot[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NODES; s++) begin
                if (inj_val[s] && inj_rdy[s]) begin
                    sent[s] <= sent[s] + 16'd1;
                    rot[s]  <= (rot[s] == 8'(NODES - 2)) ? 8'd0 : rot[s] + 8'd1;
                end
            end
        end
    end

    // Run control: state, received total, idle timeout and error count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rx_total <= '0;
            tmo      <= '0;
            err_cnt  <= '0;
        end else if (go) begin
            state    <= S_RUN;
            rx_total <= '0;
            tmo      <= '0;
            err_cnt  <= '0;
        end else begin
            if (active) rx_total <= rx_total + 32'(n_rx);
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (!active || (|ej_val) || xfer_any) tmo <= '0;
            else tmo <= tmo + 32'd1;
            case (state)
                S_RUN: begin
                    if (tmo_hit) state <= S_FAIL;
                    else if (all_done) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (tmo_hit) state <= S_FAIL;
                    else if (rx_total >= 32'(TOTAL))
                        state <= (err_cnt == 16'd0) ? S_PASS : S_FAIL;
                end
                S_PASS: begin
                    if (n_err != 9'd0) state <= S_FAIL;
                end
                default: ;
            endcase
        end
    end

    // Free-running heartbeat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hb <= '0;
        else hb <= hb + 1'b1;
    end

endmodule

// File: tb/tb_board_traffic_harness.sv
// tb_board_traffic_harness: random-stall loopback network model with
// scoreboard for board_traffic_harness (NODES=4, PKTS_PER_NODE=3).
module tb_board_traffic_harness;

    localparam int N   = 4;
    localparam int P   = 3;
    localparam int W   = 32;
    localparam int TOT = N * P;
    localparam int TMO = 100;
    localparam int HB  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N*W-1:0] inj_data;
    logic [N-1:0]   inj_val;
    logic [N-1:0]   inj_rdy;
    logic [N*W-1:0] ej_data;
    logic [N-1:0]   ej_val;
    logic [3:0]     led;
    logic           busy;
    logic [15:0]    err_cnt;

    always #5 clk = ~clk;

    board_traffic_harness #(
        .NODES(N), .PKT_W(W), .PKTS_PER_NODE(P),
        .TIMEOUT_CYC(TMO), .HB_BIT(HB)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .inj_data(inj_data), .inj_val(inj_val), .inj_rdy(inj_rdy),
        .ej_data(ej_data), .ej_val(ej_val),
        .led(led), .busy(busy), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } pkt_t;

    pkt_t        q [N][$];
    int          tests = 0;
    int          fails = 0;
    int          sent [N];
    int          cyc = 0;
    int          rx, exp_err, xfers, last_ej, stall_pct, hold_cnt;
    bit          running, drop_one, corrupt1, burst, burst_fired, freeze;
    logic [15:0] exp_seq [N][N];
    logic [N-1:0] pv, pr;
    logic [31:0] pd [N];
    logic [31:0] rxb;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pkt(int s, int k);
        int d;
        d = (s + 1 + (k % (N - 1))) % N;
        return {8'(s), 8'(d), 16'(k)};
    endfunction

    // Number of errors (0/1) the rules assign to packet d ejected at node n.
    function automatic int judge(int n, logic [31:0] d);
        int s, t, e;
        s = int'(d[31:24]);
        t = int'(d[23:16]);
        e = 0;
        if (t != n || s >= N || s == n) e = 1;
        if (!running) e = 1;
        else begin
            if (rx >= TOT) e = 1;
            rx++;
        end
`ifdef HARNESS_SEQ_CHECK_EN
        if (s < N) begin
            if (d[15:0] != exp_seq[n][s]) e = 1;
            exp_seq[n][s] = exp_seq[n][s] + 16'd1;
        end
`endif
        return e;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < N; n++) begin
            q[n].delete();
            sent[n] = 0;
            for (int s = 0; s < N; s++) exp_seq[n][s] = '0;
        end
        rx = 0; exp_err = 0; xfers = 0; hold_cnt = 0;
        running = 0; drop_one = 0; corrupt1 = 0;
        burst = 0; burst_fired = 0; freeze = 0;
        pv = '0; pr = '0;
    endtask

    task automatic forge(input int n, input logic [31:0] d);
        pkt_t p;
        p.d = d;
        p.due = cyc;
        q[n].push_back(p);
    endtask

    // One cycle: drive ready and ejections at negedge, advance one posedge.
    task automatic step();
        logic [31:0]  d;
        logic [N-1:0] x;
        pkt_t         p;
        bit           ok;
        for (int s = 0; s < N; s++)
            inj_rdy[s] = ($urandom_range(99) >= stall_pct);
        if (hold_cnt > 0) begin
            inj_rdy[2] = 1'b0;
            hold_cnt--;
        end
        if (freeze) inj_rdy = '0;
        for (int s = 0; s < N; s++) begin
            if (pv[s] && !pr[s]) begin
                check("stall_val", inj_val[s], 1);
                check("stall_data", inj_data[s*W +: W], pd[s]);
            end
        end
        x = inj_val & inj_rdy;
        for (int s = 0; s < N; s++) begin
            if (x[s]) begin
                d = exp_pkt(s, sent[s]);
                check("inj_pkt", inj_data[s*W +: W], d);
                check("inj_extra", (sent[s] < P), 1);
                sent[s]++;
                xfers++;
                if (!(drop_one && xfers == 5)) begin
                    p.d = d;
                    p.due = cyc + 2;
                    q[int'(d[23:16])].push_back(p);
                end
            end
        end
        pv = inj_val;
        pr = inj_rdy;
        for (int s = 0; s < N; s++) pd[s] = inj_data[s*W +: W];
        ej_val = '0;
        ej_data = '0;
        ok = 1;
        if (burst) begin
            for (int n = 0; n < N; n++)
                if (q[n].size() == 0 || q[n][0].due > cyc) ok = 0;
            if (ok) begin
                burst = 0;
                burst_fired = 1;
                rxb = dut.rx_total;
            end
        end
        for (int n = 0; n < N; n++) begin
            if (ok && q[n].size() > 0 && q[n][0].due <= cyc) begin
                p = q[n].pop_front();
                d = p.d;
                if (corrupt1 && n == 1) begin
                    d[23:16] = 8'd3;
                    corrupt1 = 0;
                end
                ej_val[n] = 1'b1;
                ej_data[n*W +: W] = d;
                exp_err += judge(n, d);
                last_ej = cyc;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_run();
        clear_model();
        running = 1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int i;
        i = 0;
        while (!(led[2] | led[3]) && i < lim) begin
            step();
            i++;
        end
        check("run_end", (led[2] | led[3]), 1);
        running = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ej_val = '0;
        ej_data = '0;
        #1;
        check("rst_inj_val", inj_val, 0);
        check("rst_inj_data", |inj_data, 0);
        check("rst_busy", busy, 0);
        check("rst_led", led, 0);
        check("rst_err", err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset = 1'b0; start = 1'b0;
        inj_rdy = '0; ej_val = '0; ej_data = '0;
        stall_pct = 0;
        clear_model();
        #1 reset = 1'b1;
        #1;
        check("por_inj_val", inj_val, 0);
        check("por_inj_data", |inj_data, 0);
        check("por_busy", busy, 0);
        check("por_led", led, 0);
        check("por_err", err_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("idle_no_inj", inj_val, 0);
        check("idle_busy", busy, 0);

        // Clean run, always ready.
        stall_pct = 0;
        start_run();
        wait_done(200);
        check("a_led", led[3:1], 3'b010);
        check("a_err", err_cnt, exp_err);
        check("a_xfers", xfers, TOT);
        check("a_busy", busy, 0);

        // Ejection while in PASS is an error and forces FAIL.
        forge(1, 32'h0001_0000);
        step();
        check("pass_ej_fail", led[3], 1);
        check("pass_ej_err", err_cnt, exp_err);

        // Random stalls, node 2 held off 5 cycles, start ignored mid-run.
        stall_pct = 20;
        start_run();
        step();
        check("hold_pre_val", inj_val[2], 1);
        hold_cnt = 5;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(300);
        check("b_pass", led[2], 1);
        check("b_err", err_cnt, exp_err);
        check("b_xfers", xfers, TOT);

        // Misrouted packet delivered to node 1.
        stall_pct = 0;
        start_run();
        corrupt1 = 1;
        wait_done(200);
        check("c_fail", led[3], 1);
        check("c_nopass", led[2], 0);
        check("c_err", err_cnt, exp_err);
        check("c_err_one", err_cnt, 1);

        // Dropped packet: idle timeout.
        start_run();
        drop_one = 1;
        i = 0;
        while (!(xfers == TOT && q[0].size() == 0 && q[1].size() == 0 &&
                 q[2].size() == 0 && q[3].size() == 0) && i < 200) begin
            step();
            i++;
        end
        check("d_drained", xfers, TOT);
        check("d_not_yet", led[3], 0);
        i = 0;
        while (!led[3] && i < 300) begin
            step();
            i++;
        end
        check("d_fail", led[3], 1);
        check("d_tmo_cycles", cyc - last_ej - 1, TMO);
        check("d_err", err_cnt, exp_err);
        running = 0;

        // All four nodes eject in one cycle, then reset mid-run.
        start_run();
        burst = 1;
        i = 0;
        while (!burst_fired && i < 50) begin
            step();
            i++;
        end
        check("e_burst_fired", burst_fired, 1);
        check("e_burst_rx", dut.rx_total - rxb, 4);
        check("e_busy", busy, 1);
        step();
        do_reset();
        step();
        check("e_post_rst_inj", inj_val, 0);

        // Two packets src 0 -> dst 1 arriving with seq 1 then seq 0.
        start_run();
        freeze = 1;
        forge(1, 32'h0001_0001);
        forge(1, 32'h0001_0000);
        step();
        step();
        step();
        check("f_err", err_cnt, exp_err);
`ifdef HARNESS_SEQ_CHECK_EN
        check("f_err_lit", err_cnt, 2);
`else
        check("f_err_lit", err_cnt, 0);
`endif
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
